// File: rtl/coherence_pkg.sv
// Shared encodings for the coherence bus arbiter and the cache state machines.
package coherence_pkg;

  typedef enum logic [1:0] {
    MSG_NONE   = 2'b00,
    READ_MISS  = 2'b01,
    WRITE_MISS = 2'b10,
    INVALIDATE = 2'b11
  } msg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BROADCAST,
    ST_SNOOP,
    ST_WRITEBACK,
    ST_FETCH,
    ST_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    INVALID  = 2'b01,
    SHARED   = 2'b10,
    MODIFIED = 2'b11
  } cache_state_t;

  localparam int SRC_W = 3;

  // True when two or more bits are set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  function automatic logic needs_fetch(input msg_t m);
    return (m == READ_MISS) || (m == WRITE_MISS);
  endfunction

endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// Request, snoop, broadcast and memory handshake signals of the coherence bus.
interface coherence_bus_arbiter_if #(
  parameter int NUM_CPUS = 4,
  parameter int ADDR_W   = 8
);
  logic [NUM_CPUS-1:0]        reqValid;
  logic [2*NUM_CPUS-1:0]      reqMsg;
  logic [ADDR_W*NUM_CPUS-1:0] reqAddr;
  logic [NUM_CPUS-1:0]        snoopWriteBack;
  logic                       memReady;
  logic [NUM_CPUS-1:0]        grant;
  logic                       busValid;
  logic [1:0]                 busMsg;
  logic [ADDR_W-1:0]          busAddr;
  logic [2:0]                 busSource;
  logic                       memWrite;
  logic                       memRead;
  logic [NUM_CPUS-1:0]        doneOut;
  logic                       protocolError;

  modport master (
    input  reqValid, reqMsg, reqAddr, snoopWriteBack, memReady,
    output grant, busValid, busMsg, busAddr, busSource,
           memWrite, memRead, doneOut, protocolError
  );

  modport slave (
    output reqValid, reqMsg, reqAddr, snoopWriteBack, memReady,
    input  grant, busValid, busMsg, busAddr, busSource,
           memWrite, memRead, doneOut, protocolError
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after the pointer.
module rr_arbiter #(
  parameter int NUM_CPUS = 4
) (
  input  logic [NUM_CPUS-1:0] i_eligible,
  input  logic [2:0]          i_ptr,
  output logic [NUM_CPUS-1:0] o_pick,
  output logic [2:0]          o_idx,
  output logic                o_valid
);
  always_comb begin
    int  j;
    logic found;
    o_pick  = '0;
    o_idx   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_CPUS; k++) begin
      j = (int'(i_ptr) + k) % NUM_CPUS;
      if (!found && i_eligible[j]) begin
        o_pick[j] = 1'b1;
        o_idx     = 3'(j);
        found     = 1'b1;
      end
    end
    o_valid = found;
  end
endmodule

// File: rtl/coherence_bus_arbiter.sv
// Grants one cache at a time, broadcasts its message, collects snoop write-backs, drives memory.
// IDLE arbitrate | BROADCAST bus strobe | SNOOP collect wb | WRITEBACK mem write | FETCH mem read | DONE owner pulse
module coherence_bus_arbiter
  import coherence_pkg::*;
#(
  parameter int NUM_CPUS = 4,
  parameter int ADDR_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  coherence_bus_arbiter_if.master bus
);
  arb_state_t          r_state;
  logic [2:0]          r_rr_ptr;
  logic [NUM_CPUS-1:0] r_grant;
  logic                r_bus_valid;
  msg_t                r_msg;
  logic [ADDR_W-1:0]   r_addr;
  logic [SRC_W-1:0]    r_src;
  logic                r_mem_write;
  logic                r_mem_read;
  logic [NUM_CPUS-1:0] r_done;
  logic                r_prot_err;

  logic [NUM_CPUS-1:0] w_eligible;
  logic [NUM_CPUS-1:0] w_pick;
  logic [2:0]          w_idx;
  logic                w_arb_valid;
  logic [NUM_CPUS-1:0] w_wb;

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_CPUS; i++)
      w_eligible[i] = bus.reqValid[i] && (bus.reqMsg[2*i +: 2] != MSG_NONE);
  end

  // The owner's own snoop response is meaningless and never triggers a write-back.
  assign w_wb = bus.snoopWriteBack & ~r_grant;

  rr_arbiter #(.NUM_CPUS(NUM_CPUS)) u_rr (
    .i_eligible (w_eligible),
    .i_ptr      (r_rr_ptr),
    .o_pick     (w_pick),
    .o_idx      (w_idx),
    .o_valid    (w_arb_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_bus_valid <= 1'b0;
      r_msg       <= MSG_NONE;
      r_addr      <= '0;
      r_src       <= '0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_done      <= '0;
      r_prot_err  <= 1'b0;
    end else begin
      r_bus_valid <= 1'b0;
      r_done      <= '0;
      r_prot_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_state     <= ST_BROADCAST;
            r_grant     <= w_pick;
            r_src       <= w_idx;
            r_msg       <= msg_t'(bus.reqMsg[2*w_idx +: 2]);
            r_addr      <= bus.reqAddr[ADDR_W*w_idx +: ADDR_W];
            r_bus_valid <= 1'b1;
          end
        end
        ST_BROADCAST: r_state <= ST_SNOOP;
        ST_SNOOP: begin
          r_prot_err <= multi_hot(8'(w_wb));
          if (w_wb != '0) begin
            r_state     <= ST_WRITEBACK;
            r_mem_write <= 1'b1;
          end else if (needs_fetch(r_msg)) begin
            r_state    <= ST_FETCH;
            r_mem_read <= 1'b1;
          end else begin
            r_state <= ST_DONE;
            r_done  <= r_grant;
          end
        end
        ST_WRITEBACK: begin
          if (bus.memReady) begin
            r_mem_write <= 1'b0;
            if (needs_fetch(r_msg)) begin
              r_state    <= ST_FETCH;
              r_mem_read <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= r_grant;
            end
          end
        end
        ST_FETCH: begin
          if (bus.memReady) begin
            r_mem_read <= 1'b0;
            r_state    <= ST_DONE;
            r_done     <= r_grant;
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_grant  <= '0;
          r_rr_ptr <= (r_src == 3'(NUM_CPUS - 1)) ? 3'd0 : r_src + 3'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant         = r_grant;
  assign bus.busValid      = r_bus_valid;
  assign bus.busMsg        = r_msg;
  assign bus.busAddr       = r_addr;
  assign bus.busSource     = r_src;
  assign bus.memWrite      = r_mem_write;
  assign bus.memRead       = r_mem_read;
  assign bus.doneOut       = r_done;
  assign bus.protocolError = r_prot_err;
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for the coherence bus arbiter with hand-computed expectations.
module tb_coherence_bus_arbiter;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   cyc;

  coherence_bus_arbiter_if #(.NUM_CPUS(4), .ADDR_W(8)) bus ();

  coherence_bus_arbiter #(.NUM_CPUS(4), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus_valid(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.busValid && n < max_cyc);
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.doneOut == 4'b0 && n < max_cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_grant"}, bus.grant, 0);
    check_val({tag, "_busValid"}, bus.busValid, 0);
    check_val({tag, "_busMsg"}, bus.busMsg, 0);
    check_val({tag, "_busAddr"}, bus.busAddr, 0);
    check_val({tag, "_busSource"}, bus.busSource, 0);
    check_val({tag, "_memWrite"}, bus.memWrite, 0);
    check_val({tag, "_memRead"}, bus.memRead, 0);
    check_val({tag, "_doneOut"}, bus.doneOut, 0);
    check_val({tag, "_protErr"}, bus.protocolError, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_src[5];
    exp_src = '{0, 1, 2, 3, 0};
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.reqValid       = '0;
    bus.reqMsg         = '0;
    bus.reqAddr        = '0;
    bus.snoopWriteBack = '0;
    bus.memReady       = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Fairness: all four CPUs request readMiss continuously.
    bus.reqValid = 4'b1111;
    bus.reqMsg   = 8'b0101_0101;
    bus.reqAddr  = 32'h3322_1100;
    bus.memReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_bus_valid(12, cyc);
      check_val("rr_busValid", bus.busValid, 1);
      check_val("rr_source", bus.busSource, exp_src[k]);
      check_val("rr_grant", bus.grant, 32'd1 << exp_src[k]);
      check_val("rr_gap", cyc, (k == 0) ? 1 : 5);
      if (k == 4) bus.reqValid = '0;
    end
    wait_done(10);
    check_val("rr_last_done", bus.doneOut, 4'b0001);
    tick();

    // Single readMiss from CPU1.
    bus.reqValid = 4'b0010;
    bus.reqMsg   = 8'b0000_0100;
    bus.reqAddr  = 32'h0000_3C00;
    tick();
    check_val("rm_grant", bus.grant, 4'b0010);
    check_val("rm_busValid", bus.busValid, 1);
    check_val("rm_busMsg", bus.busMsg, 2'b01);
    check_val("rm_busAddr", bus.busAddr, 8'h3C);
    check_val("rm_busSource", bus.busSource, 1);
    tick();
    check_val("rm_c2_busValid", bus.busValid, 0);
    check_val("rm_c2_memRead", bus.memRead, 0);
    tick();
    check_val("rm_c3_memRead", bus.memRead, 1);
    check_val("rm_c3_doneOut", bus.doneOut, 0);
    tick();
    check_val("rm_c4_doneOut", bus.doneOut, 4'b0010);
    check_val("rm_c4_grant", bus.grant, 4'b0010);
    check_val("rm_c4_memRead", bus.memRead, 0);
    bus.reqValid = '0;
    tick();
    check_val("rm_c5_grant", bus.grant, 0);
    check_val("rm_c5_doneOut", bus.doneOut, 0);

    // Write-back path: CPU0 writeMiss, CPU2 snoop responds, memory slow.
    bus.reqValid       = 4'b0001;
    bus.reqMsg         = 8'b0000_0010;
    bus.reqAddr        = 32'h0000_0010;
    bus.snoopWriteBack = 4'b0100;
    bus.memReady       = 1'b0;
    tick();
    check_val("wb_grant", bus.grant, 4'b0001);
    check_val("wb_busMsg", bus.busMsg, 2'b10);
    check_val("wb_busAddr", bus.busAddr, 8'h10);
    tick();
    tick();
    check_val("wb_c3_memWrite", bus.memWrite, 1);
    check_val("wb_c3_protErr", bus.protocolError, 0);
    tick();
    check_val("wb_c4_memWrite", bus.memWrite, 1);
    tick();
    check_val("wb_c5_memWrite", bus.memWrite, 1);
    check_val("wb_c5_memRead", bus.memRead, 0);
    bus.memReady = 1'b1;
    tick();
    check_val("wb_c6_memWrite", bus.memWrite, 0);
    check_val("wb_c6_memRead", bus.memRead, 1);
    tick();
    check_val("wb_c7_doneOut", bus.doneOut, 4'b0001);
    bus.reqValid       = '0;
    bus.snoopWriteBack = '0;
    tick();

    // Invalidate from CPU2; its own snoop bit must be ignored.
    bus.reqValid       = 4'b0100;
    bus.reqMsg         = 8'b0011_0000;
    bus.reqAddr        = 32'h007E_0000;
    bus.snoopWriteBack = 4'b0100;
    tick();
    check_val("inv_grant", bus.grant, 4'b0100);
    check_val("inv_busMsg", bus.busMsg, 2'b11);
    check_val("inv_busSource", bus.busSource, 2);
    check_val("inv_busAddr", bus.busAddr, 8'h7E);
    tick();
    tick();
    check_val("inv_c3_doneOut", bus.doneOut, 4'b0100);
    check_val("inv_c3_memWrite", bus.memWrite, 0);
    check_val("inv_c3_memRead", bus.memRead, 0);
    bus.reqValid       = '0;
    bus.snoopWriteBack = '0;
    tick();

    // Two snoopers respond to a CPU0 request, then reset lands in WRITEBACK.
    bus.reqValid       = 4'b0001;
    bus.reqMsg         = 8'b0000_0001;
    bus.reqAddr        = 32'h0000_0055;
    bus.snoopWriteBack = 4'b1010;
    bus.memReady       = 1'b0;
    tick();
    check_val("err_grant", bus.grant, 4'b0001);
    tick();
    check_val("err_c2_protErr", bus.protocolError, 0);
    tick();
    check_val("err_c3_protErr", bus.protocolError, 1);
    check_val("err_c3_memWrite", bus.memWrite, 1);
    tick();
    check_val("err_c4_protErr", bus.protocolError, 0);
    check_val("err_c4_memWrite", bus.memWrite, 1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    tick();
    check_all_zero("rst_cycle");
    reset = 1'b0;

    // Pointer must be back at 0: CPU0 wins over CPU3, CPU3 is served next.
    bus.reqValid       = 4'b1001;
    bus.reqMsg         = 8'b1100_0011;
    bus.reqAddr        = 32'hA3A2_A1A0;
    bus.snoopWriteBack = '0;
    bus.memReady       = 1'b1;
    tick();
    check_val("post_grant", bus.grant, 4'b0001);
    check_val("post_busAddr", bus.busAddr, 8'hA0);
    tick();
    tick();
    check_val("post_doneOut0", bus.doneOut, 4'b0001);
    bus.reqValid = 4'b1000;
    tick();
    check_val("post_idle_grant", bus.grant, 0);
    tick();
    check_val("post_grant3", bus.grant, 4'b1000);
    check_val("post_source3", bus.busSource, 3);
    check_val("post_busAddr3", bus.busAddr, 8'hA3);
    tick();
    tick();
    check_val("post_doneOut3", bus.doneOut, 4'b1000);
    bus.reqValid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/coherence_bus_arbiter.md
# coherence_bus_arbiter

Sequences coherence traffic between NUM_CPUS private caches and the shared directory/memory. Requests are read miss, write miss and invalidate, each raised by a cache's CPU-side state machine. Round-robin grants one requester at a time and broadcasts its message to the bus-side state machines of all caches. Collects their write-back responses, then drives memory write-back and fetch handshakes and signals completion to the granted cache.

## Interface
- NUM_CPUS, 4, number of cache requesters (2..8)
- ADDR_W, 8, block address width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- reqValid  in  NUM_CPUS  per-CPU request strobe; held high until that CPU's doneOut bit pulses
- reqMsg  in  2*NUM_CPUS  per-CPU message, slice i = [2i+1:2i]; 00 none, 01 readMiss, 10 writeMiss, 11 invalidate
- reqAddr  in  ADDR_W*NUM_CPUS  per-CPU block address
- snoopWriteBack  in  NUM_CPUS  per-cache bus-side write-back response, valid in SNOOP cycle
- memReady  in  1  memory accepts current memWrite/memRead this cycle
- grant  out  NUM_CPUS  one-hot owner, 0 when idle
- busValid  out  1  broadcast strobe, one cycle per transaction
- busMsg  out  2  broadcast message (same encoding as reqMsg)
- busAddr  out  ADDR_W  broadcast address
- busSource  out  3  index of granted CPU
- memWrite  out  1  write-back request to memory
- memRead  out  1  fetch request to memory
- doneOut  out  NUM_CPUS  one-cycle completion pulse to owner
- protocolError  out  1  one-cycle pulse, more than one snooper responded

## Operation
- FSM states: IDLE, BROADCAST, SNOOP, WRITEBACK, FETCH, DONE.
- IDLE: eligible[i] = reqValid[i] && reqMsg[i] != 00. If any are eligible, pick the first one at or after rrPtr, cyclically. Latch its index, msg and addr. Set grant. Go to BROADCAST.
- BROADCAST: busValid=1 with latched msg/addr/source; go to SNOOP.
- SNOOP: compute wb = snoopWriteBack & ~grant.
  - The source's own bit is ignored.
  - If popcount(wb) > 1, pulse protocolError; the transaction still proceeds.
  - If wb != 0, go to WRITEBACK.
  - Otherwise, readMiss or writeMiss goes to FETCH, and invalidate goes to DONE.
- WRITEBACK: memWrite=1 until memReady is sampled high. Then readMiss or writeMiss goes to FETCH, and invalidate goes to DONE.
- FETCH: memRead=1 until memReady is sampled high; then go to DONE.
- DONE: doneOut[source]=1 for one cycle. grant stays set through this cycle. rrPtr <= (source+1) mod NUM_CPUS. Go to IDLE.
- Latched msg/addr/source stay constant from grant to DONE. Input changes by the owner mid-transaction are ignored. Deasserting reqValid does not abort.
- Non-owners' requests wait; they are never dropped.

## Timing
- Reset values:
  - state IDLE, rrPtr 0
  - grant 0, busValid 0, busMsg 00, busAddr 0, busSource 0
  - memWrite 0, memRead 0, doneOut 0, protocolError 0
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- Request first seen high in IDLE at cycle 0:
  - grant appears at cycle 1 together with busValid.
  - SNOOP is at cycle 2.
- Minimum latency with memReady already high:
  - invalidate, no write-back: doneOut at cycle 3.
  - readMiss, no write-back: doneOut at cycle 4.
  - readMiss with write-back: doneOut at cycle 5.
- memReady is only meaningful in WRITEBACK and FETCH; it is ignored elsewhere.
- Back-to-back transactions: IDLE is entered for exactly one cycle between DONE and the next BROADCAST.
- Reset asserted mid-transaction: immediate return to reset values. No doneOut is issued. Requesters must re-present.

## Structure
- Shared package coherence_pkg holds:
  - message encodings MSG_NONE/READ_MISS/WRITE_MISS/INVALIDATE
  - arbiter state encodings
  - cache-state encodings INVALID=01, SHARED=10, MODIFIED=11, reused by the cache FSMs
- Sub-module rr_arbiter (inputs: eligible vector and pointer; output: one-hot pick plus index) is purely combinational. It is instantiated once and is separately unit-testable.

## Test plan
- Single readMiss: CPU1 reqMsg=01, addr=0x3C, no snoop, memReady=1. Required response: busValid at cycle 1 with msg 01, addr 0x3C, source 1; memRead at cycle 3; doneOut=0010 at cycle 4.
- Write-back path: CPU0 writeMiss at 0x10, snoopWriteBack=0100 in SNOOP, memReady delayed 3 cycles in WRITEBACK. Required response: memWrite held 3 cycles, then memRead, then doneOut=0001.
- Round-robin fairness: all 4 CPUs request continuously. Required response: grants in order 0,1,2,3,0; no CPU is granted twice before the others.
- Invalidate with source self-response: CPU2 msg=11 with snoopWriteBack=0100. Required response: no memWrite, no memRead, doneOut=0100 at cycle 3.
- Error pulse and reset mid-op: snoopWriteBack=1010 for a CPU0 request. Required response: protocolError pulses once in SNOOP. Then assert reset during WRITEBACK; all outputs read 0 the next cycle and rrPtr returns to 0.
